// File: rtl/fir16_out_stage.sv
// fir16_out_stage: decimate, round/shift, saturate and FIFO-buffer FIR accumulator output
module fir16_out_stage #(
  parameter int DECIM = 4,
  parameter int SHIFT = 12,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [35:0]     y_in,
  input  logic                   y_in_valid,
  output logic signed [15:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  input  logic                   clr_flags
);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic signed [36:0] RND = 37'sd1 <<< (SHIFT - 1);
  localparam logic signed [36:0] MAXV = 37'sd32767;
  localparam logic signed [36:0] MINV = -37'sd32768;

  logic [PW-1:0]        phase_q, phase_d;
  logic                 s1_valid_q, s1_valid_d;
  logic signed [36:0]   r_q, r_d;
  logic                 s2_valid_q, s2_valid_d;
  logic signed [15:0]   s2_data_q, s2_data_d;
  logic signed [15:0]   mem_q [DEPTH];
  logic signed [15:0]   mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sat_q, sat_d, ovf_q, ovf_d;
  logic                 keep, hi, lo, full, pop, push, drop;
  logic signed [36:0]   sum;

  // decimation, rounding and saturation pipeline
  always_comb begin
    keep       = y_in_valid && phase_q == '0;
    phase_d    = y_in_valid ? (phase_q == PW'(DECIM - 1) ? '0 : phase_q + 1'b1) : phase_q;
    sum        = $signed({y_in[35], y_in}) + RND;
    s1_valid_d = keep;
    r_d        = keep ? sum >>> SHIFT : r_q;
    hi         = r_q > MAXV;
    lo         = r_q < MINV;
    s2_valid_d = s1_valid_q;
    s2_data_d  = !s1_valid_q ? s2_data_q : hi ? 16'sh7fff : lo ? 16'sh8000 : r_q[15:0];
  end

  // output FIFO bookkeeping; a pop frees the slot for a same-cycle push when full
  always_comb begin
    full        = level_q == LW'(DEPTH);
    pop         = out_valid_q && out_ready;
    push        = s2_valid_q && (!full || pop);
    drop        = s2_valid_q && full && !pop;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = push && wr_ptr_q == AW'(i) ? s2_data_q : mem_q[i];
    wr_ptr_d    = push ? (wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d    = pop ? (rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    level_d     = level_q + LW'(push) - LW'(pop);
    out_valid_d = level_d != '0;
    sat_d       = !clr_flags && (sat_q || (s1_valid_q && (hi || lo)));
    ovf_d       = !clr_flags && (ovf_q || drop);
  end

  // state registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= '0;
      s1_valid_q  <= 1'b0;
      r_q         <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      s1_valid_q  <= s1_valid_d;
      r_q         <= r_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_data   = out_valid_q ? mem_q[rd_ptr_q] : '0;
  assign out_valid  = out_valid_q;
  assign fifo_level = level_q;
  assign sat_flag   = sat_q;
  assign ovf_flag   = ovf_q;
endmodule

// File: tb/tb_fir16_out_stage.sv
// tb_fir16_out_stage: DECIM=1 and DECIM=4 instances checked against a queue-based model
module tb_fir16_out_stage;
  logic clk = 0, reset_n = 0;
  logic signed [35:0] y_in = '0;
  logic y_in_valid = 0, out_ready = 0, clr_flags = 0;
  logic signed [15:0] od [2];
  logic ov [2], sf [2], of [2];
  logic [2:0] lv [2];
  int tests = 0, fails = 0;
  int fq [2][$];
  int ph [2], p1 [2], p2 [2];
  bit p1v [2], p2v [2], p1s [2], msat [2], movf [2];
  int got [$];

  always #5 clk = ~clk;

  fir16_out_stage #(.DECIM(1), .SHIFT(12), .DEPTH(4)) u_d1 (
    .clk(clk), .reset_n(reset_n), .y_in(y_in), .y_in_valid(y_in_valid),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .fifo_level(lv[0]),
    .sat_flag(sf[0]), .ovf_flag(of[0]), .clr_flags(clr_flags));

  fir16_out_stage #(.DECIM(4), .SHIFT(12), .DEPTH(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .y_in(y_in), .y_in_valid(y_in_valid),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .fifo_level(lv[1]),
    .sat_flag(sf[1]), .ovf_flag(of[1]), .clr_flags(clr_flags));

  function automatic int decim(int i);
    return i != 0 ? 4 : 1;
  endfunction

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      fq[i].delete();
      ph[i] = 0; p1v[i] = 0; p2v[i] = 0; msat[i] = 0; movf[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit pop, sset, oset;
      longint r;
      pop  = fq[i].size() > 0 && out_ready;
      sset = p1v[i] && p1s[i];
      oset = p2v[i] && fq[i].size() == 4 && !pop;
      if (pop) void'(fq[i].pop_front());
      if (p2v[i] && !oset) fq[i].push_back(p2[i]);
      msat[i] = clr_flags ? 0 : (msat[i] | sset);
      movf[i] = clr_flags ? 0 : (movf[i] | oset);
      p2v[i] = p1v[i];
      p2[i]  = p1[i];
      p1v[i] = y_in_valid && ph[i] == 0;
      if (p1v[i]) begin
        r = (longint'(y_in) + 2048) >>> 12;
        p1s[i] = r > 32767 || r < -32768;
        p1[i]  = r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
      end
      if (y_in_valid) ph[i] = (ph[i] + 1) % decim(i);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d.out_valid", decim(i)), ov[i], fq[i].size() > 0);
      chk($sformatf("d%0d.out_data", decim(i)), od[i], fq[i].size() > 0 ? fq[i][0] : 0);
      chk($sformatf("d%0d.fifo_level", decim(i)), lv[i], fq[i].size());
      chk($sformatf("d%0d.sat_flag", decim(i)), sf[i], msat[i]);
      chk($sformatf("d%0d.ovf_flag", decim(i)), of[i], movf[i]);
    end
  endtask

  task automatic step(input logic v, input longint y, input logic rdy, input logic clr);
    @(negedge clk);
    y_in_valid = v; y_in = y[35:0]; out_ready = rdy; clr_flags = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; y_in_valid = 0; out_ready = 0; clr_flags = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    longint y;
    do_reset();
    // rounding with DECIM=1 and 3-edge latency
    step(1, 4096, 1, 0);  got.push_back(od[0]);
    step(1, 2048, 1, 0);  got.push_back(od[0]);
    step(1, 2047, 1, 0);  got.push_back(od[0]);
    step(1, -2048, 1, 0); got.push_back(od[0]);
    step(1, -2049, 1, 0); got.push_back(od[0]);
    step(0, 0, 1, 0);     got.push_back(od[0]);
    step(0, 0, 1, 0);     got.push_back(od[0]);
    chk("t1.lat_edge2", got[1], 0);
    chk("t1.out0", got[2], 1);
    chk("t1.out1", got[3], 1);
    chk("t1.out2", got[4], 0);
    chk("t1.out3", got[5], 0);
    chk("t1.out4", got[6], -1);
    // saturation and sticky flag clear
    do_reset();
    step(1, 64'sd1 <<< 27, 0, 0);
    step(1, -(64'sd1 <<< 28), 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t2.sat_d1", sf[0], 1);
    chk("t2.head_d1", od[0], 32767);
    step(0, 0, 1, 0);
    chk("t2.neg_d1", od[0], -32768);
    step(0, 0, 0, 1);
    chk("t2.clr_d1", sf[0], 0);
    // decimation by 4
    do_reset();
    got.delete();
    for (int k = 0; k < 15; k++) begin
      step(k < 12, 4096 * k, 1, 0);
      if (ov[1]) got.push_back(od[1]);
    end
    chk("t3.count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t3.o0", got[0], 0);
      chk("t3.o1", got[1], 4);
      chk("t3.o2", got[2], 8);
    end
    // full FIFO with simultaneous pop and push, then overflow
    do_reset();
    for (int k = 1; k <= 5; k++) step(1, 4096 * k, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("t5.level", lv[0], 4);
    chk("t5.ovf", of[0], 0);
    chk("t5.head", od[0], 2);
    step(1, 4096 * 6, 0, 0);
    step(1, 4096 * 7, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t4.level", lv[0], 4);
    chk("t4.ovf", of[0], 1);
    chk("t4.head", od[0], 2);
    // mid-stream reset with FIFO at 3
    do_reset();
    for (int k = 1; k <= 3; k++) step(1, 4096 * k, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6.pre_level", lv[0], 3);
    do_reset();
    chk("t6.valid", ov[0], 0);
    chk("t6.level", lv[0], 0);
    step(1, 8192, 0, 0);
    step(1, 4096 * 9, 0, 0);
    step(0, 0, 0, 0);
    chk("t6.first_d4", od[1], 2);
    // randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      y = $urandom_range(0, 1) != 0 ? (longint'({$urandom(), $urandom()}) >>> 28)
                                    : longint'($urandom_range(0, 1 << 24)) - (1 << 23);
      step($urandom_range(0, 3) != 0, y, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
